// File: rtl/drf_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding and requester IDs.
package drf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic REQ_CU = 1'b0;  // control unit
  localparam logic REQ_LD = 1'b1;  // loader / debug requester

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. On contention the requester not granted last wins;
// tying last_i to REQ_LD turns this into fixed priority for requester 0.
module mem_arb_pick
  import drf_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic vld_o
);

  always_comb begin
    vld_o = req0_i | req1_i;
    if (req0_i && req1_i) win_o = ~last_i;
    else if (req1_i)      win_o = REQ_LD;
    else                  win_o = REQ_CU;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter, one access per 4 cycles (IDLE/ADDR/ACCESS/DONE).
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority to req0.
module mem_arbiter
  import drf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_addr_wr_en,
  output logic              mem_read_en,
  output logic              mem_wr_en,
  output logic              busy
);

  arb_state_e state_q;
  logic       we_q;
  logic       win;
  logic       win_vld;
  logic       last_win;

  mem_arb_pick u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (last_win),
    .win_o  (win),
    .vld_o  (win_vld)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                last_win <= REQ_LD;
    else if (state_q == ST_IDLE && win_vld)    last_win <= win;
  end
`else
  assign last_win = REQ_LD;
`endif

  // Outputs are registered alongside the state so each one is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      we_q           <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
      rdata          <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_addr_wr_en <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_wr_en      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q        <= ST_ADDR;
            we_q           <= (win == REQ_LD) ? we1    : we0;
            mem_addr       <= (win == REQ_LD) ? addr1  : addr0;
            mem_wdata      <= (win == REQ_LD) ? wdata1 : wdata0;
            gnt0           <= (win == REQ_CU);
            gnt1           <= (win == REQ_LD);
            busy           <= 1'b1;
            mem_addr_wr_en <= 1'b1;
          end
        end
        ST_ADDR: begin
          state_q        <= ST_ACCESS;
          mem_addr_wr_en <= 1'b0;
          mem_read_en    <= ~we_q;
          mem_wr_en      <= we_q;
        end
        ST_ACCESS: begin
          state_q     <= ST_DONE;
          mem_read_en <= 1'b0;
          mem_wr_en   <= 1'b0;
          if (!we_q) rdata <= mem_rdata;
          ack0        <= gnt0;
          ack1        <= gnt1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences and
// random traffic against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_addr_wr_en, mem_read_en, mem_wr_en;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_wr_en(mem_addr_wr_en), .mem_read_en(mem_read_en),
    .mem_wr_en(mem_wr_en), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction granted on edge t0 occupies edges t0..t0+3;
  // cycles after edges t0, t0+1, t0+2 are address, access and completion phases.
  int            ecnt;
  int            t0;
  bit            act;
  bit            m_who, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;

  task automatic model_reset();
    act = 0; m_last = 1'b1; m_rdata = '0; m_addr = '0; m_wd = '0;
  endtask

  task automatic model_edge();
    bit w;
    ecnt++;
    if (!rst_n) return;
    if (act && ecnt - t0 == 2 && !m_we) m_rdata = mem_rdata;
    if ((!act || ecnt - t0 >= 4) && (req0 || req1)) begin
      if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
        w = ~m_last;
`else
        w = 1'b0;
`endif
      end else w = req1;
      m_last = w;
      m_who  = w;
      m_we   = w ? we1 : we0;
      m_addr = w ? addr1 : addr0;
      m_wd   = w ? wdata1 : wdata0;
      t0     = ecnt;
      act    = 1;
    end
  endtask

  task automatic check_outputs();
    int k;
    logic [7:0] e;
    k = act ? ecnt - t0 : 99;
    e = '0;
    if (k <= 2) begin
      e[7] = (m_who == 1'b0);
      e[6] = (m_who == 1'b1);
      e[3] = 1'b1;
    end
    if (k == 2) begin e[5] = (m_who == 1'b0); e[4] = (m_who == 1'b1); end
    if (k == 0) e[2] = 1'b1;
    if (k == 1) begin e[1] = ~m_we; e[0] = m_we; end
    chk("ctrl{gnt0,gnt1,ack0,ack1,busy,aw,rd,wr}",
        {24'd0, gnt0, gnt1, ack0, ack1, busy, mem_addr_wr_en, mem_read_en, mem_wr_en},
        {24'd0, e});
    chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
    if (k == 0) chk("mem_addr", {22'd0, mem_addr}, {22'd0, m_addr});
    if (k == 1 && m_we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wd});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            who;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] mrd;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int   g1, g2;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 10'h155, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 8'h5C, 8'h11, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 10'h2AB, 8'h00, 8'h3C, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 10'h000, 8'hFF, 8'h77, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 10'h0FF, 8'h99, 8'h00, 8'h00};

    ecnt = 0; t0 = 0;
    idle_inputs();
    mem_rdata = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_ctrl", {24'd0, gnt0, gnt1, ack0, ack1, busy, mem_addr_wr_en, mem_read_en, mem_wr_en}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed single transactions
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].who) begin req1 = 1; we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wd; end
      else             begin req0 = 1; we0 = vecs[i].we; addr0 = vecs[i].addr; wdata0 = vecs[i].wd; end
      mem_rdata = vecs[i].mrd;
      tick();
      req0 = 0; req1 = 0;
      chk("vec_addr_phase", {21'd0, mem_addr_wr_en, mem_addr}, {21'd0, 1'b1, vecs[i].addr});
      tick();
      chk("vec_access_en", {30'd0, mem_read_en, mem_wr_en}, {30'd0, ~vecs[i].we, vecs[i].we});
      if (vecs[i].we) chk("vec_wdata", {24'd0, mem_wdata}, {24'd0, vecs[i].wd});
      tick();
      chk("vec_ack", {30'd0, ack0, ack1}, {30'd0, ~vecs[i].who, vecs[i].who});
      chk("vec_rdata", {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
      tick();
      chk("vec_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Contention held for 8 cycles from reset state
    do_reset();
    idle_inputs();
    req0 = 1; req1 = 1;
    g1 = -1; g2 = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_addr_wr_en) begin
        if (g1 < 0) g1 = gnt1; else g2 = gnt1;
      end
    end
    req0 = 0; req1 = 0;
`ifdef MEM_ARB_RR_EN
    chk("contention_grants", {g1[15:0], g2[15:0]}, {16'd0, 16'd1});
`else
    chk("contention_grants", {g1[15:0], g2[15:0]}, {16'd0, 16'd0});
`endif
    repeat (4) tick();

    // Reset asserted during the access cycle of a write
    req1 = 1; we1 = 1; addr1 = 10'h2C3; wdata1 = 8'h6E;
    tick();
    req1 = 0;
    tick();
    chk("pre_reset_wr_en", {31'd0, mem_wr_en}, 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_outs", {28'd0, mem_wr_en, gnt0, gnt1, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_reset_no_ack", {29'd0, ack0, ack1, busy}, 32'd0);
    end

    // Early drop: requester changes address during the address cycle
    req0 = 1; we0 = 0; addr0 = 10'h155; mem_rdata = 8'h4B;
    tick();
    req0 = 0; addr0 = 10'h000;
    tick();
    chk("early_drop_read_en", {31'd0, mem_read_en}, 32'd1);
    tick();
    chk("early_drop_ack0", {24'd0, ack0, rdata[6:0]}, {24'd0, 1'b1, 7'h4B});
    tick();

    // Late request raised during the access cycle of a requester-0 transaction
    req0 = 1; we0 = 1; addr0 = 10'h011; wdata0 = 8'h22;
    tick();
    req0 = 0;
    tick();
    req1 = 1; we1 = 0; addr1 = 10'h1E0;
    tick();
    tick();
    chk("late_idle_gap", {30'd0, gnt1, busy}, 32'd0);
    tick();
    req1 = 0;
    chk("late_grant", {29'd0, gnt1, mem_addr_wr_en, gnt0}, {29'd0, 3'b110});
    repeat (3) tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req0      = ($urandom_range(0, 2) == 0);
      req1      = ($urandom_range(0, 2) == 0);
      we0       = $urandom_range(0, 1) == 1;
      we1       = $urandom_range(0, 1) == 1;
      addr0     = AW'($urandom);
      addr1     = AW'($urandom);
      wdata0    = DW'($urandom);
      wdata1    = DW'($urandom);
      mem_rdata = DW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory address width (2-bit bank plus 8-bit offset).
REQ-002 SHALL have parameter DATA_W, default 8, data-memory word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  access request (0 = control unit, 1 = loader/debug requester).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  and wdata0/wdata1  input  DATA_W  per-requester access address and write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  grant; ack0/ack1  output  1  one-cycle completion pulse; rdata  output  DATA_W  read data.
REQ-009 SHALL have memory-side ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W, mem_addr_wr_en, mem_read_en, mem_wr_en  output  1 each.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, ACCESS, DONE; transitions IDLE->ADDR on any req, ADDR->ACCESS, ACCESS->DONE and DONE->IDLE unconditionally.
REQ-012 SHALL, in IDLE with a request pending, select the winner and latch its we, addr and wdata on the same edge that enters ADDR.
REQ-013 SHALL hold the winner's gnt high in ADDR, ACCESS and DONE; at most one gnt is high at a time.
REQ-014 SHALL assert mem_addr_wr_en for exactly the ADDR cycle, with mem_addr equal to the latched address.
REQ-015 SHALL assert exactly one of mem_read_en or mem_wr_en for exactly the ACCESS cycle, according to the latched we; mem_wdata equals the latched wdata during ACCESS.
REQ-016 SHALL register mem_rdata into rdata on the ACCESS->DONE edge for reads only; rdata holds until the next read completes.
REQ-017 SHALL pulse the winner's ack for exactly the DONE cycle: ack is high 3 cycles after the edge that sampled req.
REQ-018 SHALL give a throughput of one access per 4 cycles, with a mandatory IDLE cycle between back-to-back accesses.
REQ-019 SHALL complete a latched transaction and pulse ack even if the requester drops req after the grant; changes to addr, we or wdata after latching SHALL be ignored.
REQ-020 SHALL ignore requests arriving outside IDLE until the FSM returns to IDLE; a requester holding req is served then.
REQ-021 SHALL pass addresses unmodified, with no wrap or bank translation; bank bits are supplied by the requester.
REQ-022 SHALL keep all mem_* enables low in IDLE and DONE.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-transaction, asynchronously enter IDLE.
REQ-024 SHALL, during reset, force gnt*, ack*, busy and all mem_* enables to 0, and clear rdata, mem_addr and mem_wdata to 0.
REQ-025 SHALL clear the round-robin last-winner register to 1, so requester 0 wins the first contention.
REQ-026 SHALL perform no partial write: if reset is asserted during ACCESS, mem_wr_en drops immediately.

Configuration
REQ-027 SHALL support macro MEM_ARB_RR_EN: when defined, contention is resolved round-robin (the winner is the requester not granted last; a sole requester always wins).
REQ-028 SHALL, without MEM_ARB_RR_EN, use fixed priority (req0 always beats req1); the last-winner register is then absent.

Structure
REQ-029 SHALL take the FSM state encoding (2-bit: IDLE=0, ADDR=1, ACCESS=2, DONE=3) and requester-ID constants from the shared package drf_pkg.
REQ-030 SHALL place winner selection in one combinational sub-module, mem_arb_pick (inputs req0, req1, last winner; output winner ID, valid).

Verification
REQ-031 SHALL cover: single read, req0=1, we0=0, addr0=0x155, mem_rdata=0xA5 -> mem_addr_wr_en at cycle+1, mem_read_en at cycle+2, ack0 and rdata=0xA5 at cycle+3.
REQ-032 SHALL cover: single write, req1=1, we1=1, addr1=0x3FF, wdata1=0x5C -> mem_wr_en for one cycle with mem_addr=0x3FF and mem_wdata=0x5C, then ack1; gnt0 stays 0 throughout.
REQ-033 SHALL cover: contention, req0=req1=1 held for 8 cycles -> with MEM_ARB_RR_EN the grants are 0 then 1; without it the grants are 0 then 0.
REQ-034 SHALL cover: reset mid-op, rst_n low during ACCESS of a write -> mem_wr_en, gnt*, busy go to 0 immediately; after release, busy=0 and no ack pulses.
REQ-035 SHALL cover: early drop, req0 deasserted and addr0 changed to 0x000 in the ADDR cycle -> access uses the latched address and ack0 still pulses at cycle+3.
REQ-036 SHALL cover: late request, req1 raised during the ACCESS of a requester-0 transaction -> req1 is granted in the cycle after DONE, and the next ADDR state follows the IDLE cycle.
